// File: rtl/rlc_pkg.sv
// Types and constants shared by the RLC fetch controller and the RLC weight decoder.
package rlc_pkg;

  localparam int DATA_W         = 16;
  localparam int VALS_PER_BLOCK = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_REQ,
    ST_READ,
    ST_WAIT_DATA,
    ST_ZERO,
    ST_HOLDOFF,
    ST_FINISH
  } fetch_state_e;

endpackage

// File: rtl/rlc_rdlat_pipe.sv
// Shift register tracking the single outstanding SRAM read; strobe_o marks the cycle its data is valid.
// Latency RD_LAT cycles from issue_i; no backpressure, flush_i drops the read in flight.
module rlc_rdlat_pipe #(
  parameter int RD_LAT = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic flush_i,
  input  logic issue_i,
  output logic busy_o,
  output logic strobe_o
);

  logic [RD_LAT-1:0] vld_q;
  logic [RD_LAT:0]   shift_d;

  assign shift_d = {vld_q, issue_i};

  always_ff @(posedge clk) begin
    if (reset || flush_i) begin
      vld_q <= '0;
    end else begin
      vld_q <= shift_d[RD_LAT-1:0];
    end
  end

  assign busy_o   = |vld_q;
  assign strobe_o = vld_q[RD_LAT-1];

endmodule

// File: rtl/rlc_fetch_ctrl.sv
// Feeds the RLC decoder from weight SRAM, one word per level-held request; optional prefetch slot under RLC_FETCH_PREFETCH_EN.
// Request to dec_valid is RD_LAT+2 cycles (1 on a prefetch hit); the decoder request is the only backpressure.
module rlc_fetch_ctrl #(
  parameter int ADDR_W      = 10,
  parameter int DATA_W      = rlc_pkg::DATA_W,
  parameter int RD_LAT      = 1,
  parameter int HOLDOFF_CYC = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] num_words,
  output logic              dec_start,
  input  logic              dec_req,
  output logic [DATA_W-1:0] dec_din,
  output logic              dec_valid,
  input  logic              dec_done,
  output logic              sram_en,
  output logic [ADDR_W-1:0] sram_addr,
  input  logic [DATA_W-1:0] sram_rdata,
  output logic              busy,
  output logic              done,
  output logic              err_underrun
);
  import rlc_pkg::*;

  localparam int HOLD_W = (HOLDOFF_CYC > 1) ? $clog2(HOLDOFF_CYC) : 1;

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [ADDR_W-1:0] rem_q, rem_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [DATA_W-1:0] din_q, din_d;
  logic              vld_q, vld_d;
  logic              dstart_q, dstart_d;
  logic              done_q, done_d;
  logic              busy_q, busy_d;
  logic              err_q, err_d;
  logic              rd_issue, rd_busy, rd_strobe, flush;
`ifdef RLC_FETCH_PREFETCH_EN
  logic              pf_vld_q, pf_vld_d;
  logic [DATA_W-1:0] pf_dat_q, pf_dat_d;
`endif

  rlc_rdlat_pipe #(.RD_LAT(RD_LAT)) u_rdlat (
    .clk      (clk),
    .reset    (reset),
    .flush_i  (flush),
    .issue_i  (rd_issue),
    .busy_o   (rd_busy),
    .strobe_o (rd_strobe)
  );

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    rem_d    = rem_q;
    hold_d   = '0;
    din_d    = din_q;
    vld_d    = 1'b0;
    dstart_d = 1'b0;
    done_d   = 1'b0;
    busy_d   = busy_q;
    err_d    = err_q;
    rd_issue = 1'b0;
    flush    = 1'b0;
`ifdef RLC_FETCH_PREFETCH_EN
    pf_vld_d = pf_vld_q;
    pf_dat_d = pf_dat_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          ptr_d    = base_addr;
          rem_d    = num_words;
          err_d    = 1'b0;
          dstart_d = 1'b1;
          busy_d   = 1'b1;
          state_d  = ST_WAIT_REQ;
        end
      end
      ST_WAIT_REQ: begin
        if (dec_done) begin
          state_d = ST_FINISH;
        end else if (dec_req) begin
`ifdef RLC_FETCH_PREFETCH_EN
          if (pf_vld_q) begin
            din_d    = pf_dat_q;
            vld_d    = 1'b1;
            pf_vld_d = 1'b0;
            state_d  = ST_HOLDOFF;
          end else
`endif
          // a read landing in the same cycle as the request is handed straight over
          if (rd_strobe) begin
            din_d   = sram_rdata;
            vld_d   = 1'b1;
            state_d = ST_HOLDOFF;
          end else if (rd_busy) begin
            state_d = ST_WAIT_DATA;
          end else if (rem_q != '0) begin
            state_d = ST_READ;
          end else begin
            state_d = ST_ZERO;
          end
        end
      end
      ST_READ: begin
        rd_issue = 1'b1;
        state_d  = ST_WAIT_DATA;
      end
      ST_WAIT_DATA: begin
        if (rd_strobe) begin
          din_d   = sram_rdata;
          vld_d   = 1'b1;
          state_d = ST_HOLDOFF;
        end
      end
      ST_ZERO: begin
        din_d   = '0;
        vld_d   = 1'b1;
        err_d   = 1'b1;
        state_d = ST_HOLDOFF;
      end
      ST_HOLDOFF: begin
        if (dec_done) begin
          state_d = ST_FINISH;
        end else if (hold_q == HOLD_W'(HOLDOFF_CYC - 1)) begin
          state_d = ST_WAIT_REQ;
        end else begin
          hold_d = hold_q + HOLD_W'(1);
        end
      end
      ST_FINISH: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        flush   = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

`ifdef RLC_FETCH_PREFETCH_EN
    // background fill of the prefetch slot while the decoder is not asking
    if (!dec_done && (state_q == ST_HOLDOFF || (state_q == ST_WAIT_REQ && !dec_req))) begin
      if (rd_strobe) begin
        pf_vld_d = 1'b1;
        pf_dat_d = sram_rdata;
      end else if (!pf_vld_q && !rd_busy && rem_q != '0) begin
        rd_issue = 1'b1;
      end
    end
    if (state_q == ST_FINISH) begin
      pf_vld_d = 1'b0;
    end
`endif

    if (rd_issue) begin
      ptr_d = ptr_q + ADDR_W'(1);
      rem_d = rem_q - ADDR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      ptr_q    <= '0;
      rem_q    <= '0;
      hold_q   <= '0;
      din_q    <= '0;
      vld_q    <= 1'b0;
      dstart_q <= 1'b0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
      err_q    <= 1'b0;
`ifdef RLC_FETCH_PREFETCH_EN
      pf_vld_q <= 1'b0;
      pf_dat_q <= '0;
`endif
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      rem_q    <= rem_d;
      hold_q   <= hold_d;
      din_q    <= din_d;
      vld_q    <= vld_d;
      dstart_q <= dstart_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
      err_q    <= err_d;
`ifdef RLC_FETCH_PREFETCH_EN
      pf_vld_q <= pf_vld_d;
      pf_dat_q <= pf_dat_d;
`endif
    end
  end

  assign dec_start    = dstart_q;
  assign dec_din      = din_q;
  assign dec_valid    = vld_q;
  assign sram_en      = rd_issue;
  assign sram_addr    = ptr_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign err_underrun = err_q;

endmodule

// File: tb/tb_rlc_fetch_ctrl.sv
// Scoreboard bench for rlc_fetch_ctrl: directed blocks push expected events, a negedge monitor pops and compares.
module tb_rlc_fetch_ctrl;

`ifdef RLC_FETCH_PREFETCH_EN
  localparam int RD_LAT = 2;
`else
  localparam int RD_LAT = 1;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [9:0]  base_addr = '0;
  logic [9:0]  num_words = '0;
  logic        dec_start;
  logic        dec_req = 1'b0;
  logic [15:0] dec_din;
  logic        dec_valid;
  logic        dec_done = 1'b0;
  logic        sram_en;
  logic [9:0]  sram_addr;
  logic [15:0] sram_rdata;
  logic        busy;
  logic        done;
  logic        err_underrun;

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;
  bit mon_en = 1'b0;

  typedef struct {
    logic [15:0] dat;
    int          cyc;
  } ev_t;

  ev_t exp_dv[$];
  ev_t exp_rd[$];
  ev_t exp_done[$];
  ev_t exp_ds[$];

  logic [15:0] mem [0:1023];
  logic [15:0] rd_pipe [0:3];

  rlc_fetch_ctrl #(.ADDR_W(10), .DATA_W(16), .RD_LAT(RD_LAT), .HOLDOFF_CYC(2)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .base_addr    (base_addr),
    .num_words    (num_words),
    .dec_start    (dec_start),
    .dec_req      (dec_req),
    .dec_din      (dec_din),
    .dec_valid    (dec_valid),
    .dec_done     (dec_done),
    .sram_en      (sram_en),
    .sram_addr    (sram_addr),
    .sram_rdata   (sram_rdata),
    .busy         (busy),
    .done         (done),
    .err_underrun (err_underrun)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (sram_en) rd_pipe[0] <= mem[sram_addr];
    for (int i = 1; i < 4; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign sram_rdata = rd_pipe[RD_LAT-1];

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endfunction

  function automatic void unexpected(string nm);
    n_chk++;
    n_err++;
    $display("FAIL %s: unexpected event at cycle %0d", nm, cyc);
  endfunction

  always @(negedge clk) begin : monitor
    ev_t e;
    if (mon_en) begin
      if (dec_valid) begin
        if (exp_dv.size() == 0) unexpected("dec_valid");
        else begin
          e = exp_dv.pop_front();
          chk("dec_din", 32'(dec_din), 32'(e.dat));
          chk("dec_valid_cycle", 32'(cyc), 32'(e.cyc));
        end
      end
      if (sram_en) begin
        if (exp_rd.size() == 0) unexpected("sram_en");
        else begin
          e = exp_rd.pop_front();
          chk("sram_addr", 32'(sram_addr), 32'(e.dat));
          chk("sram_en_cycle", 32'(cyc), 32'(e.cyc));
        end
      end
      if (done) begin
        if (exp_done.size() == 0) unexpected("done");
        else begin
          e = exp_done.pop_front();
          chk("done_cycle", 32'(cyc), 32'(e.cyc));
        end
      end
      if (dec_start) begin
        if (exp_ds.size() == 0) unexpected("dec_start");
        else begin
          e = exp_ds.pop_front();
          chk("dec_start_cycle", 32'(cyc), 32'(e.cyc));
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_start(input logic [9:0] b, input logic [9:0] n);
    @(posedge clk);
    #1;
    exp_ds.push_back('{16'h0, cyc + 1});
    base_addr = b;
    num_words = n;
    start     = 1'b1;
    step(1);
    start     = 1'b0;
  endtask

  // pulse dec_done while in WAIT_REQ; done follows two edges later
  task automatic finish_blk(input string nm);
    exp_done.push_back('{16'h0, cyc + 2});
    dec_done = 1'b1;
    step(1);
    dec_done = 1'b0;
    step(2);
    @(negedge clk);
    chk({nm, "_busy_after_done"}, 32'(busy), 32'h0);
  endtask

  task automatic drain(input string nm);
    chk({nm, "_missing_dec_valid"}, 32'(exp_dv.size()), 32'h0);
    chk({nm, "_missing_sram_en"}, 32'(exp_rd.size()), 32'h0);
    chk({nm, "_missing_done"}, 32'(exp_done.size()), 32'h0);
    chk({nm, "_missing_dec_start"}, 32'(exp_ds.size()), 32'h0);
  endtask

  task automatic chk_idle(input string nm);
    chk({nm, "_busy"}, 32'(busy), 32'h0);
    chk({nm, "_done"}, 32'(done), 32'h0);
    chk({nm, "_dec_valid"}, 32'(dec_valid), 32'h0);
    chk({nm, "_dec_start"}, 32'(dec_start), 32'h0);
    chk({nm, "_dec_din"}, 32'(dec_din), 32'h0);
    chk({nm, "_sram_en"}, 32'(sram_en), 32'h0);
    chk({nm, "_sram_addr"}, 32'(sram_addr), 32'h0);
    chk({nm, "_err_underrun"}, 32'(err_underrun), 32'h0);
  endtask

  initial begin : watchdog
    #100000;
    n_err++;
    $display("FAIL watchdog: bench did not complete, cycle %0d", cyc);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int c;
    for (int i = 0; i < 1024; i++) mem[i] = 16'hC000 | 16'(i);
    mem[16'h010] = 16'h1234;
    mem[16'h011] = 16'hABCD;
    for (int i = 0; i < 4; i++) rd_pipe[i] = 16'h0;

    step(3);
    reset = 1'b0;
    @(negedge clk);
    chk_idle("reset");
    mon_en = 1'b1;

`ifndef RLC_FETCH_PREFETCH_EN
    // basic: one read per request, 3-cycle latency
    do_start(10'h010, 10'd2);
    @(negedge clk);
    chk("t1_busy", 32'(busy), 32'h1);
    step(1);
    c = cyc;
    exp_rd.push_back('{16'h0010, c + 1});
    exp_dv.push_back('{16'h1234, c + 3});
    dec_req = 1'b1;
    step(5);
    dec_req = 1'b0;
    step(3);
    @(negedge clk);
    chk("t1_din_hold", 32'(dec_din), 32'h1234);
    step(1);
    c = cyc;
    exp_rd.push_back('{16'h0011, c + 1});
    exp_dv.push_back('{16'hABCD, c + 3});
    dec_req = 1'b1;
    step(1);
    dec_req = 1'b0;
    step(5);
    finish_blk("t1");
    drain("t1");

    // under-run with an empty budget
    do_start(10'h100, 10'd0);
    c = cyc;
    exp_dv.push_back('{16'h0000, c + 2});
    dec_req = 1'b1;
    step(1);
    dec_req = 1'b0;
    step(3);
    @(negedge clk);
    chk("t3_err_set", 32'(err_underrun), 32'h1);
    step(1);
    finish_blk("t3");
    chk("t3_err_sticky_after_done", 32'(err_underrun), 32'h1);
    drain("t3");

    // level-held request: 4 words every 5 cycles, then the zero word
    do_start(10'h020, 10'd4);
    @(negedge clk);
    chk("t2_err_cleared_by_start", 32'(err_underrun), 32'h0);
    step(1);
    c = cyc;
    for (int k = 0; k < 4; k++) begin
      exp_rd.push_back('{16'(16'h0020 + k), c + 1 + 5 * k});
      exp_dv.push_back('{16'(16'hC020 + k), c + 3 + 5 * k});
    end
    exp_dv.push_back('{16'h0000, c + 22});
    dec_req = 1'b1;
    step(21);
    dec_req = 1'b0;
    @(negedge clk);
    chk("t2_err_before_5th", 32'(err_underrun), 32'h0);
    step(1);
    @(negedge clk);
    chk("t2_err_after_5th", 32'(err_underrun), 32'h1);
    step(3);
    finish_blk("t2");
    drain("t2");

    // done during HOLDOFF, later requests ignored
    do_start(10'h030, 10'd3);
    c = cyc;
    exp_rd.push_back('{16'h0030, c + 1});
    exp_dv.push_back('{16'hC030, c + 3});
    dec_req = 1'b1;
    step(1);
    dec_req = 1'b0;
    step(2);
    exp_done.push_back('{16'h0, c + 5});
    dec_done = 1'b1;
    step(1);
    dec_done = 1'b0;
    step(1);
    @(negedge clk);
    chk("t4_busy", 32'(busy), 32'h0);
    step(1);
    dec_req = 1'b1;
    step(4);
    dec_req = 1'b0;
    step(1);
    drain("t4");

    // address wrap
    do_start(10'h3FF, 10'd2);
    c = cyc;
    exp_rd.push_back('{16'h03FF, c + 1});
    exp_rd.push_back('{16'h0000, c + 6});
    exp_dv.push_back('{16'hC3FF, c + 3});
    exp_dv.push_back('{16'hC000, c + 8});
    dec_req = 1'b1;
    step(6);
    dec_req = 1'b0;
    step(4);
    finish_blk("t5");
    drain("t5");

    // reset during WAIT_DATA drops the read
    do_start(10'h040, 10'd1);
    c = cyc;
    exp_rd.push_back('{16'h0040, c + 1});
    dec_req = 1'b1;
    step(2);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    dec_req = 1'b0;
    @(negedge clk);
    chk_idle("t6_mid_reset");
    step(5);
    drain("t6");
`else
    // prefetch: words already in the slot answer in one cycle
    do_start(10'h060, 10'd3);
    exp_rd.push_back('{16'h0060, cyc});
    step(5);
    c = cyc;
    exp_dv.push_back('{16'hC060, c + 1});
    exp_rd.push_back('{16'h0061, c + 1});
    dec_req = 1'b1;
    step(1);
    dec_req = 1'b0;
    step(5);
    c = cyc;
    exp_dv.push_back('{16'hC061, c + 1});
    exp_rd.push_back('{16'h0062, c + 1});
    dec_req = 1'b1;
    step(1);
    dec_req = 1'b0;
    step(5);
    finish_blk("p1");
    drain("p1");

    // slot flushed by FINISH: fresh block fetches its own first word
    do_start(10'h050, 10'd1);
    exp_rd.push_back('{16'h0050, cyc});
    step(5);
    c = cyc;
    exp_dv.push_back('{16'hC050, c + 1});
    dec_req = 1'b1;
    step(1);
    dec_req = 1'b0;
    step(4);
    c = cyc;
    exp_dv.push_back('{16'h0000, c + 2});
    dec_req = 1'b1;
    step(1);
    dec_req = 1'b0;
    step(1);
    @(negedge clk);
    chk("p2_err_set", 32'(err_underrun), 32'h1);
    step(3);
    finish_blk("p2");
    drain("p2");
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
